uart_rx_sampler: RTL and testbench
==================================

Name: uart_rx_sampler

Overview:
- Receive front end of the full-duplex UART, directly upstream of the deframer.
- Synchronises the asynchronous rx line and detects the start bit using 16x-oversampled baud ticks.
- Mid-bit samples the 11-bit frame {stop, parity, data[7:0], start} LSB first.
- Presents the frame as a stable 11-bit word with a one-cycle def_en strobe. That is exactly the deframer's data_in/def_en input.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period. Must be even and at least 4.
- FRAME_BITS, 11, bits per frame including start, parity and stop.

Ports:
- clk  input  1  system clock, single domain
- rst  input  1  synchronous, active-high reset
- baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate. May be held high continuously.
- rx  input  1  asynchronous serial line, idle high
- frame  output  FRAME_BITS  last completed frame. Bit 0 is start, [8:1] data, 9 parity, 10 stop.
- def_en  output  1  one-clk pulse when frame is updated
- busy  output  1  high while not in IDLE
- false_start  output  1  one-clk pulse when a start edge fails mid-bit validation

Behaviour:
- Reset values: frame = 0, def_en = 0, busy = 0, false_start = 0, synchroniser flops = 1, state = IDLE, counters = 0. All logic uses the synchronous, active-high rst.
- rx passes through a 2-FF synchroniser to give rx_s. Synchroniser latency is 2 clk.
- Counters:
  - tick_cnt is $clog2(OVERSAMPLE) bits.
  - bit_idx is $clog2(FRAME_BITS) bits.
  - shift_reg is FRAME_BITS bits, internal only. frame is never written during shifting.
- States:
  - IDLE: busy = 0. On baud_tick with rx_s == 0, set tick_cnt = 0 and go to START.
  - START: on each baud_tick:
    - If tick_cnt != OVERSAMPLE/2-1, increment tick_cnt.
    - Otherwise sample rx_s (the 8th tick after detection).
    - Sample 0: write shift_reg[0] = 0, set bit_idx = 1, clear tick_cnt, go to DATA.
    - Sample 1: pulse false_start and return to IDLE.
  - DATA: on each baud_tick:
    - If tick_cnt != OVERSAMPLE-1, increment tick_cnt.
    - Otherwise write shift_reg[bit_idx] = rx_s, clear tick_cnt, increment bit_idx.
    - When the sample at bit_idx == FRAME_BITS-1 (stop bit) is taken, go to DONE.
  - DONE (one clk): load frame = shift_reg including the just-sampled stop bit. Assert def_en for this cycle only, then go to IDLE.
- Sampling interval: successive samples are exactly OVERSAMPLE ticks apart, starting from the start-bit midpoint.
- Latency: def_en is high in the clk after the stop-bit sample. frame holds its value until the next DONE.
- No checking: stop = 0 or wrong parity is still captured and strobed. The deframer and the parity checker own those checks.
- Back-to-back frames: from IDLE, a start low seen on the first tick after DONE is accepted. No idle gap is required beyond the stop-bit remainder.
- No baud_tick: counters and state are frozen.
- rst mid-frame: returns to IDLE next clk with no def_en, and frame is cleared to 0.
- rx low in IDLE without a tick: ignored until the next baud_tick.
- false_start and def_en are never high in the same cycle.

Decomposition:
- Package uart_pkg holds:
  - Constants: FRAME_BITS = 11, OVERSAMPLE = 16, START_POS = 0, PARITY_POS = 9, STOP_POS = 10.
  - An rx_state_t enum {IDLE, START, DATA, DONE}.
- The transmitter's framer and the deframer share this package.
- One sub-module, sync_2ff: a 2-flop synchroniser with a reset-value parameter, set to 1 here.

Test Plan:
- Valid frame, baud_tick every 4 clk: rx carries byte 0xA5 LSB first, even parity 0, stop 1. Expect:
  - exactly one def_en pulse;
  - frame == 11'h54A;
  - busy high from detection until the DONE cycle.
- Glitch: rx low for 4 ticks, then high. Expect one false_start pulse, no def_en, frame unchanged, return to IDLE.
- Back-to-back: frames 0x00 (expect frame 11'h400), then 0xFF with parity 0 (expect frame 11'h5FE), with no idle bits between them. Expect two def_en pulses exactly 11*16 ticks apart.
- Bad stop: 0x3C frame with the stop bit driven 0. Expect def_en to pulse and frame == 11'h078.
- Reset mid-frame: assert rst during data bit 4 of a frame. Expect:
  - next clk: busy = 0, frame = 0, no def_en;
  - a following valid 0x5A frame gives frame == 11'h4B4.
- baud_tick held high continuously (OVERSAMPLE = 16 clk per bit): a 0xA5 frame still yields frame == 11'h54A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and receive-state encoding, used by the framer,
// the deframer and this receive sampler.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int OVERSAMPLE = 16;
  localparam int START_POS  = 0;
  localparam int PARITY_POS = 9;
  localparam int STOP_POS   = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    DONE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Signal bundle between the receive sampler and its neighbours.
// frame is stable whenever def_en is low; def_en and false_start are
// single-cycle strobes with no back-pressure (the consumer must take the
// frame in the def_en cycle).
interface uart_rx_sampler_if;
  import uart_pkg::*;

  logic                  baud_tick;
  logic                  rx;
  logic [FRAME_BITS-1:0] frame;
  logic                  def_en;
  logic                  busy;
  logic                  false_start;
  rx_state_t             state;

  modport master (
    output baud_tick, rx,
    input  frame, def_en, busy, false_start, state
  );

  modport slave (
    input  baud_tick, rx,
    output frame, def_en, busy, false_start, state
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; the reset value
// is chosen to match the line's idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1_q <= RESET_VAL;
      ff2_q <= RESET_VAL;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronises rx, validates the start bit at its
// midpoint and mid-bit samples the rest of the frame for the deframer.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int FRAME_BITS = 11
) (
  input  logic               clk,
  input  logic               rst,
  uart_rx_sampler_if.slave   bus
);
  import uart_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);

  logic                  rx_s;
  rx_state_t             state_q;
  logic [TW-1:0]         tick_cnt_q;
  logic [BW-1:0]         bit_idx_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  def_en_q;
  logic                  busy_q;
  logic                  false_start_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rx),
    .q_o (rx_s)
  );

  // Outputs are registered on the transition into a state, so def_en and
  // frame become visible together in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      frame_q       <= '0;
      def_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      false_start_q <= 1'b0;
    end else begin
      def_en_q      <= 1'b0;
      false_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.baud_tick && !rx_s) begin
            tick_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          if (bus.baud_tick) begin
            if (tick_cnt_q != HALF_LAST) begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end else if (!rx_s) begin
              shift_q[START_POS] <= 1'b0;
              bit_idx_q          <= BW'(1);
              tick_cnt_q         <= '0;
              state_q            <= DATA;
            end else begin
              false_start_q <= 1'b1;
              tick_cnt_q    <= '0;
              busy_q        <= 1'b0;
              state_q       <= IDLE;
            end
          end
        end
        DATA: begin
          if (bus.baud_tick) begin
            if (tick_cnt_q != FULL_LAST) begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end else begin
              shift_q[bit_idx_q] <= rx_s;
              tick_cnt_q         <= '0;
              if (bit_idx_q == LAST_BIT) begin
                // Stop bit goes straight into frame; no framing check here.
                frame_q   <= {rx_s, shift_q[FRAME_BITS-2:0]};
                def_en_q  <= 1'b1;
                bit_idx_q <= '0;
                state_q   <= DONE;
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
              end
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.frame       = frame_q;
  assign bus.def_en      = def_en_q;
  assign bus.busy        = busy_q;
  assign bus.false_start = false_start_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: drives serial frames against
// hand-computed 11-bit words and watches the def_en / false_start strobes.
module tb_uart_rx_sampler;
  import uart_pkg::*;

  logic clk;
  logic rst;
  uart_rx_sampler_if bus();

  uart_rx_sampler #(.OVERSAMPLE(16), .FRAME_BITS(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int tick_div = 4;
  int tick_total = 0;
  int def_cnt = 0;
  int fs_cnt = 0;
  logic [10:0] last_frame = '0;
  logic [10:0] frame_log[$];
  int def_tick[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // baud tick generator: one pulse every tick_div clocks (held high at 1)
  initial begin : tick_gen
    int cnt;
    cnt = 0;
    bus.baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cnt >= tick_div - 1) begin
        bus.baud_tick = 1'b1;
        cnt = 0;
      end else begin
        bus.baud_tick = 1'b0;
        cnt++;
      end
    end
  end

  // strobe monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.baud_tick === 1'b1) tick_total++;
    if (bus.def_en === 1'b1) begin
      def_cnt++;
      last_frame = bus.frame;
      frame_log.push_back(bus.frame);
      def_tick.push_back(tick_total);
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_at_def_en: busy=%b required 1", bus.busy);
      end
    end
    if (bus.false_start === 1'b1) fs_cnt++;
    if (bus.def_en === 1'b1 || bus.false_start === 1'b1) begin
      checks++;
      if (bus.def_en === 1'b1 && bus.false_start === 1'b1) begin
        errors++;
        $display("FAIL strobe_exclusive: def_en and false_start both high");
      end
    end
  end

  // driver tasks
  function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(negedge clk);
      if (bus.baud_tick === 1'b1) k++;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.rx = bits[i];
      wait_ticks(16);
    end
  endtask

  task automatic wait_def_en(input string name, output bit seen);
    int n;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.def_en === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: def_en not seen within 400 cycles", name);
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.frame !== 11'h000) begin errors++; $display("FAIL reset_frame: got %h want 000", bus.frame); end
    checks++; if (bus.def_en !== 1'b0) begin errors++; $display("FAIL reset_def_en: got %b want 0", bus.def_en); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.false_start !== 1'b0) begin errors++; $display("FAIL reset_false_start: got %b want 0", bus.false_start); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", bus.state); end
    rst = 1'b0;
    wait_ticks(4);
  endtask

  task automatic test_valid_frame();
    int d0;
    bit seen;
    logic [10:0] bits;
    d0 = def_cnt;
    bits = mk(8'hA5, 1'b0, 1'b1);
    send_bits(bits, 0, 0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL valid_busy_mid: got %b want 1", bus.busy); end
    send_bits(bits, 1, 9);
    bus.rx = 1'b1;
    wait_def_en("valid_def_en", seen);
    if (seen) begin
      checks++; if (bus.frame !== 11'h54A) begin errors++; $display("FAIL valid_frame: got %h want 54A", bus.frame); end
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL valid_busy_after: got %b want 0", bus.busy); end
      checks++; if (bus.def_en !== 1'b0) begin errors++; $display("FAIL valid_def_en_width: got %b want 0", bus.def_en); end
    end
    wait_ticks(16);
    checks++; if (def_cnt !== d0 + 1) begin errors++; $display("FAIL valid_def_count: got %0d want %0d", def_cnt - d0, 1); end
  endtask

  task automatic test_glitch();
    int d0, f0;
    d0 = def_cnt;
    f0 = fs_cnt;
    bus.rx = 1'b0;
    wait_ticks(4);
    bus.rx = 1'b1;
    wait_ticks(16);
    checks++; if (fs_cnt !== f0 + 1) begin errors++; $display("FAIL glitch_false_start: got %0d pulses want 1", fs_cnt - f0); end
    checks++; if (def_cnt !== d0) begin errors++; $display("FAIL glitch_def_en: got %0d pulses want 0", def_cnt - d0); end
    checks++; if (bus.frame !== 11'h54A) begin errors++; $display("FAIL glitch_frame: got %h want 54A", bus.frame); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", bus.busy); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d want IDLE", bus.state); end
  endtask

  task automatic test_back_to_back();
    int d0, n0;
    d0 = def_cnt;
    n0 = frame_log.size();
    send_bits(mk(8'h00, 1'b0, 1'b1), 0, 10);
    send_bits(mk(8'hFF, 1'b0, 1'b1), 0, 10);
    bus.rx = 1'b1;
    wait_ticks(16);
    checks++;
    if (def_cnt !== d0 + 2) begin
      errors++;
      $display("FAIL b2b_def_count: got %0d want 2", def_cnt - d0);
    end else begin
      checks++; if (frame_log[n0] !== 11'h400) begin errors++; $display("FAIL b2b_frame0: got %h want 400", frame_log[n0]); end
      checks++; if (frame_log[n0+1] !== 11'h5FE) begin errors++; $display("FAIL b2b_frame1: got %h want 5FE", frame_log[n0+1]); end
      checks++;
      if (def_tick[n0+1] - def_tick[n0] !== 176) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d ticks want 176", def_tick[n0+1] - def_tick[n0]);
      end
    end
  endtask

  task automatic test_bad_stop();
    int d0, f0;
    bit seen;
    d0 = def_cnt;
    f0 = fs_cnt;
    send_bits(mk(8'h3C, 1'b0, 1'b0), 0, 9);
    bus.rx = 1'b0;
    wait_def_en("badstop_def_en", seen);
    bus.rx = 1'b1;
    if (seen) begin
      checks++; if (bus.frame !== 11'h078) begin errors++; $display("FAIL badstop_frame: got %h want 078", bus.frame); end
    end
    wait_ticks(16);
    checks++; if (def_cnt !== d0 + 1) begin errors++; $display("FAIL badstop_def_count: got %0d want 1", def_cnt - d0); end
    checks++; if (fs_cnt !== f0) begin errors++; $display("FAIL badstop_false_start: got %0d want 0", fs_cnt - f0); end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    logic [10:0] bits;
    d0 = def_cnt;
    bits = mk(8'h5A, 1'b0, 1'b1);
    send_bits(bits, 0, 4);
    bus.rx = bits[5];
    wait_ticks(8);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.frame !== 11'h000) begin errors++; $display("FAIL rstmid_frame: got %h want 000", bus.frame); end
    checks++; if (bus.def_en !== 1'b0) begin errors++; $display("FAIL rstmid_def_en: got %b want 0", bus.def_en); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL rstmid_state: got %0d want IDLE", bus.state); end
    rst = 1'b0;
    bus.rx = 1'b1;
    wait_ticks(20);
    checks++; if (def_cnt !== d0) begin errors++; $display("FAIL rstmid_no_def_en: got %0d want 0", def_cnt - d0); end
    send_bits(bits, 0, 10);
    wait_ticks(16);
    checks++; if (def_cnt !== d0 + 1) begin errors++; $display("FAIL rstmid_def_count: got %0d want 1", def_cnt - d0); end
    checks++; if (last_frame !== 11'h4B4) begin errors++; $display("FAIL rstmid_frame_after: got %h want 4B4", last_frame); end
  endtask

  task automatic test_tick_held();
    int d0;
    tick_div = 1;
    bus.rx = 1'b1;
    wait_ticks(20);
    d0 = def_cnt;
    send_bits(mk(8'hA5, 1'b0, 1'b1), 0, 10);
    wait_ticks(16);
    checks++; if (def_cnt !== d0 + 1) begin errors++; $display("FAIL held_def_count: got %0d want 1", def_cnt - d0); end
    checks++; if (last_frame !== 11'h54A) begin errors++; $display("FAIL held_frame: got %h want 54A", last_frame); end
  endtask

  initial begin : main
    rst = 1'b1;
    bus.rx = 1'b1;
    test_reset();
    test_valid_frame();
    test_glitch();
    test_back_to_back();
    test_bad_stop();
    test_reset_mid_frame();
    test_tick_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
